mult_arbiter: RTL and testbench

- Shares one multi-cycle multiplier (start/done handshake, 64-bit operands and product) among NUM_REQ requesters, e.g. several square-root or other iterative units.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences the multiplier start pulse, waits for done, and returns the product to the owning requester.
- Includes a watchdog that aborts a hung multiply.

---
 rtl/mult_arbiter.sv | 159 +++++++++++++++
 tb/tb_mult_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier among NUM_REQ requesters.
// One transaction in flight; a watchdog aborts a multiply that never completes.
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_mcand,
    input  logic [NUM_REQ*WIDTH-1:0] req_mplier,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     resp_err,
    output logic                     busy,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_mcand,
    output logic [WIDTH-1:0]         mult_mplier,
    input  logic [WIDTH-1:0]         mult_product,
    input  logic                     mult_done
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDXW:0]   NREQ     = (IDXW+1)'(NUM_REQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
    localparam logic [WDW-1:0]  WD_LAST  = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              err_q, err_d;
    logic [WDW-1:0]    wdog_q, wdog_d;

    logic [WIDTH-1:0]  mc_arr [NUM_REQ];
    logic [WIDTH-1:0]  mp_arr [NUM_REQ];
    logic [NUM_REQ-1:0] owner_oh;
    logic              pick_hit;
    logic [IDXW-1:0]   pick_idx;
    logic [IDXW:0]     cand;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign mc_arr[i] = req_mcand[i*WIDTH +: WIDTH];
        assign mp_arr[i] = req_mplier[i*WIDTH +: WIDTH];
    end

    assign owner_oh = NUM_REQ'(1) << owner_q;

    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDXW+1)'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!pick_hit && req[cand[IDXW-1:0]]) begin
                pick_hit = 1'b1;
                pick_idx = cand[IDXW-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            data_q   <= data_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        data_d     = data_q;
        err_d      = err_q;
        wdog_d     = wdog_q;
        mult_start = 1'b0;
        busy       = 1'b1;
        gnt        = owner_oh;
        resp_valid = '0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                gnt  = '0;
                if (pick_hit) begin
                    owner_d  = pick_idx;
                    mcand_d  = mc_arr[pick_idx];
                    mplier_d = mp_arr[pick_idx];
                    wdog_d   = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mult_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A done arriving on the timeout cycle still counts as success.
                if (mult_done) begin
                    data_d  = mult_product;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = owner_oh;
                ptr_d      = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_data   = (state_q == RESP) ? data_q : '0;
    assign resp_err    = (state_q == RESP) ? err_q : 1'b0;
    assign mult_mcand  = (state_q != IDLE) ? mcand_q : '0;
    assign mult_mplier = (state_q != IDLE) ? mplier_q : '0;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed and random jobs against a round-robin
// model and a behavioural multiplier with programmable latency.
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int TO = 8;

    logic             clock;
    logic             reset;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_mcand;
    logic [N*W-1:0]   req_mplier;
    logic [N-1:0]     gnt;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_data;
    logic             resp_err;
    logic             busy;
    logic             mult_start;
    logic [W-1:0]     mult_mcand;
    logic [W-1:0]     mult_mplier;
    logic [W-1:0]     mult_product;
    logic             mult_done;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] mc [N];
    logic [W-1:0] mp [N];
    int           ptr_m;
    int           lat_sel;
    bit           hang;
    logic         inj_done;

    mult_arbiter #(
        .NUM_REQ(N),
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_mcand   (req_mcand),
        .req_mplier  (req_mplier),
        .gnt         (gnt),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .busy        (busy),
        .mult_start  (mult_start),
        .mult_mcand  (mult_mcand),
        .mult_mplier (mult_mplier),
        .mult_product(mult_product),
        .mult_done   (mult_done)
    );

    always #5 clock = ~clock;

    // Behavioural multiplier: done lat_sel cycles after start unless hung.
    int           m_cnt;
    logic         m_done;
    logic [W-1:0] m_prod;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else begin
            m_done <= 1'b0;
            if (mult_start) begin
                m_cnt <= lat_sel;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !hang) begin
                    m_done <= 1'b1;
                    m_prod <= mult_mcand * mult_mplier;
                end
            end
        end
    end

    assign mult_done    = m_done | inj_done;
    assign mult_product = inj_done ? 64'hDEAD_BEEF_0BAD_F00D : m_prod;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < N; i++) begin
            req_mcand[i*W +: W]  = mc[i];
            req_mplier[i*W +: W] = mp[i];
        end
    endtask

    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic job(input logic [N-1:0] r, input int lat,
                       input bit hang_i, input bit poke);
        int           o;
        int           n;
        bit           got;
        logic [W-1:0] expd;
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
        req     = r;
        pack_ops();
        lat_sel = lat;
        hang    = hang_i;
        o       = pick(r, ptr_m);
        expd    = hang_i ? '0 : mc[o] * mp[o];
        @(negedge clock);
        chk("issue_gnt", gnt, N'(1) << o);
        chk("issue_start", mult_start, 1);
        chk("issue_busy", busy, 1);
        chk("issue_mcand", mult_mcand, mc[o]);
        chk("issue_mplier", mult_mplier, mp[o]);
        if (poke) begin
            req_mcand[o*W +: W] = {$urandom, $urandom};
        end
        got = 0;
        n   = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            n++;
            if (resp_valid != 0) begin
                got = 1;
            end else begin
                chk("wait_start_low", mult_start, 0);
                chk("wait_mcand", mult_mcand, mc[o]);
                chk("wait_gnt", gnt, N'(1) << o);
            end
        end
        chk("resp_seen", got, 1);
        chk("resp_valid", resp_valid, N'(1) << o);
        chk("resp_data", resp_data, expd);
        chk("resp_err", resp_err, hang_i);
        chk("resp_latency", n, hang_i ? TO + 1 : lat + 2);
        ptr_m = (o + 1) % N;
        @(negedge clock);
        chk("post_resp_valid", resp_valid, 0);
    endtask

    initial begin
        clock      = 1'b0;
        reset      = 1'b1;
        req        = '0;
        req_mcand  = '0;
        req_mplier = '0;
        lat_sel    = 1;
        hang       = 0;
        inj_done   = 1'b0;
        ptr_m      = 0;
        for (int i = 0; i < N; i++) begin
            mc[i] = '0;
            mp[i] = '0;
        end

        @(negedge clock);
        chk("rst_gnt", gnt, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", mult_start, 0);
        chk("rst_mcand", mult_mcand, 0);
        reset = 1'b0;

        // Single request, 3*5 with 4-cycle multiplier.
        mc[0] = 3;
        mp[0] = 5;
        job(4'b0001, 4, 0, 0);

        // Contention: two full rounds with operands (i+2, i+2).
        for (int i = 0; i < N; i++) begin
            mc[i] = i + 2;
            mp[i] = i + 2;
        end
        for (int j = 0; j < 2 * N; j++) begin
            job(4'b1111, 3, 0, 0);
        end

        // Wrap: serve 2, then 0101 must go to 0.
        job(4'b0100, 2, 0, 0);
        job(4'b0101, 2, 0, 0);

        // Done coinciding with the timeout cycle: done wins.
        job(4'b0010, TO - 1, 0, 0);

        // Watchdog abort, then a stray done in IDLE.
        job(4'b1000, 3, 1, 0);
        req      = '0;
        inj_done = 1'b1;
        @(negedge clock);
        chk("late_done_valid", resp_valid, 0);
        chk("late_done_busy", busy, 0);
        inj_done = 1'b0;
        @(negedge clock);
        chk("late_done_valid2", resp_valid, 0);
        chk("late_done_busy2", busy, 0);
        hang = 0;

        // Operand stability: owner's req_mcand changes during WAIT.
        mc[2] = 64'h1234_5678_9ABC_DEF0;
        mp[2] = 64'h0000_0000_0000_0011;
        job(4'b0100, 5, 0, 1);

        // Leave pointer at 2, then reset mid-multiply.
        job(4'b0010, 2, 0, 0);
        req     = 4'b0010;
        lat_sel = 5;
        repeat (3) @(negedge clock);
        req = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_wait_gnt", gnt, 0);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_start", mult_start, 0);
        chk("rst_wait_mcand", mult_mcand, 0);
        chk("rst_wait_mplier", mult_mplier, 0);
        chk("rst_wait_data", resp_data, 0);
        chk("rst_wait_err", resp_err, 0);
        chk("rst_wait_valid", resp_valid, 0);
        @(negedge clock);
        chk("rst_hold_valid", resp_valid, 0);
        reset = 1'b0;
        ptr_m = 0;
        @(negedge clock);
        chk("rst_after_valid", resp_valid, 0);
        job(4'b0101, 3, 0, 0);
        mc[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        mp[3] = 64'h3;
        job(4'b1000, 4, 0, 0);

        // Random jobs.
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < N; i++) begin
                mc[i] = {$urandom, $urandom};
                mp[i] = {$urandom, $urandom};
            end
            job(N'($urandom_range(1, 15)), $urandom_range(1, TO - 1), 0,
                bit'($urandom_range(0, 1)));
        end

        req = '0;
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
